// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator: pixel strobe, coordinates, syncs, blanking and frame strobes.
// Latency: status outputs are registered from the next counter values, so they change on the same edge as pixel_x/pixel_y.
// Backpressure: none; enable=0 freezes all state and gates the strobes.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COORD_W   = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               p_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               vblank,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_DISP   = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_DISP   = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_nxt;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic               tick;
    logic               h_wrap;
    logic               v_wrap;
    logic               line_q;
    logic               frame_q;

    always_comb begin
        tick    = enable && (div_cnt == DIV_LAST);
        div_nxt = div_cnt;
        if (enable) begin
            div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
        h_wrap = tick && (pixel_x == H_LAST);
        v_wrap = h_wrap && (pixel_y == V_LAST);
        x_nxt  = pixel_x;
        y_nxt  = pixel_y;
        if (tick) begin
            x_nxt = h_wrap ? '0 : pixel_x + COORD_W'(1);
        end
        if (h_wrap) begin
            y_nxt = v_wrap ? '0 : pixel_y + COORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_count <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            video_on    <= 1'b1;
            vblank      <= 1'b0;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            div_cnt  <= div_nxt;
            pixel_x  <= x_nxt;
            pixel_y  <= y_nxt;
            // Decoding the next coordinates keeps sync aligned with pixel_x/pixel_y.
            hsync    <= ((x_nxt >= HS_BEG) && (x_nxt <= HS_END)) ? HSYNC_POL : ~HSYNC_POL;
            vsync    <= ((y_nxt >= VS_BEG) && (y_nxt <= VS_END)) ? VSYNC_POL : ~VSYNC_POL;
            video_on <= (x_nxt < H_DISP) && (y_nxt < V_DISP);
            vblank   <= (y_nxt >= V_DISP);
            line_q   <= h_wrap;
            frame_q  <= v_wrap;
            if (v_wrap) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
        end
    end

    // Gating with reset keeps the CLK_DIV=1 strobe low while held in reset.
    assign p_tick      = tick && reset;
    assign line_start  = line_q && enable;
    assign frame_start = frame_q && enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a reduced frame and a CLK_DIV=1 active-high variant.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default configuration
    logic       rst_d, en_d, pt_d, hs_d, vs_d, vo_d, vb_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;
    logic [7:0] fc_d;
    // reduced frame: H 64/4/8/4 (80), V 48/2/2/3 (55), CLK_DIV=2
    logic       rst_m, en_m, pt_m, hs_m, vs_m, vo_m, vb_m, ls_m, fs_m;
    logic [9:0] x_m, y_m;
    logic [7:0] fc_m;
    // alternate: H 8/2/3/2 (15), V 4/1/1/1 (7), CLK_DIV=1, active-high syncs
    logic       rst_a, en_a, pt_a, hs_a, vs_a, vo_a, vb_a, ls_a, fs_a;
    logic [3:0] x_a, y_a;
    logic [7:0] fc_a;

    vga_timing_gen u_def (
        .clk(clk), .reset(rst_d), .enable(en_d), .p_tick(pt_d), .hsync(hs_d), .vsync(vs_d),
        .video_on(vo_d), .vblank(vb_d), .pixel_x(x_d), .pixel_y(y_d),
        .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
    );

    vga_timing_gen #(
        .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_mid (
        .clk(clk), .reset(rst_m), .enable(en_m), .p_tick(pt_m), .hsync(hs_m), .vsync(vs_m),
        .video_on(vo_m), .vblank(vb_m), .pixel_x(x_m), .pixel_y(y_m),
        .line_start(ls_m), .frame_start(fs_m), .frame_count(fc_m)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COORD_W(4), .FRAME_W(8)
    ) u_alt (
        .clk(clk), .reset(rst_a), .enable(en_a), .p_tick(pt_a), .hsync(hs_a), .vsync(vs_a),
        .video_on(vo_a), .vblank(vb_a), .pixel_x(x_a), .pixel_y(y_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if (x_d !== 10'd0 || y_d !== 10'd0) begin
            errors++; $display("FAIL reset_xy got x=%0d y=%0d want 0 0", x_d, y_d);
        end
        checks++;
        if (hs_d !== 1'b1 || vs_d !== 1'b1 || vo_d !== 1'b1 || vb_d !== 1'b0) begin
            errors++; $display("FAIL reset_status got hs=%b vs=%b vo=%b vb=%b want 1 1 1 0", hs_d, vs_d, vo_d, vb_d);
        end
        checks++;
        if (fc_d !== 8'd0 || pt_d !== 1'b0 || ls_d !== 1'b0 || fs_d !== 1'b0) begin
            errors++; $display("FAIL reset_strobes got fc=%0d pt=%b ls=%b fs=%b want 0 0 0 0", fc_d, pt_d, ls_d, fs_d);
        end
        rst_d = 1'b1;
        #1;
        checks++;
        if (pt_d !== 1'b0 || ls_d !== 1'b0) begin
            errors++; $display("FAIL release_no_tick got pt=%b ls=%b want 0 0", pt_d, ls_d);
        end
        step();
        checks++;
        if (pt_d !== 1'b1 || x_d !== 10'd0) begin
            errors++; $display("FAIL first_tick got pt=%b x=%0d want 1 0", pt_d, x_d);
        end
        step();
        checks++;
        if (pt_d !== 1'b0 || x_d !== 10'd1 || fs_d !== 1'b0) begin
            errors++; $display("FAIL second_pixel got pt=%b x=%0d fs=%b want 0 1 0", pt_d, x_d, fs_d);
        end
    endtask

    task automatic test_line();
        int  lo_min = 9999, lo_max = -1, lo_cnt = 0, vid_bad = 0;
        bit  seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            step();
            if (hs_d === 1'b0) begin
                if (int'(x_d) < lo_min) lo_min = int'(x_d);
                if (int'(x_d) > lo_max) lo_max = int'(x_d);
                if (pt_d === 1'b1) lo_cnt++;
            end
            if (!ls_d && vo_d !== (x_d < 10'd640)) vid_bad++;
            if (ls_d === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL line_wrap_timeout got no line_start want one within 2000 clks");
        end
        checks++;
        if (x_d !== 10'd0 || y_d !== 10'd1 || fs_d !== 1'b0 || vo_d !== 1'b1) begin
            errors++; $display("FAIL line_wrap got x=%0d y=%0d fs=%b vo=%b want 0 1 0 1", x_d, y_d, fs_d, vo_d);
        end
        checks++;
        if (lo_min != 656 || lo_max != 751 || lo_cnt != 96) begin
            errors++; $display("FAIL hsync_window got %0d..%0d ticks=%0d want 656..751 ticks=96", lo_min, lo_max, lo_cnt);
        end
        checks++;
        if (vid_bad != 0) begin
            errors++; $display("FAIL video_on_line got %0d bad cycles want 0", vid_bad);
        end
        step();
        checks++;
        if (ls_d !== 1'b0) begin
            errors++; $display("FAIL line_start_width got ls=%b want 0", ls_d);
        end
    endtask

    task automatic test_pause();
        int  bad = 0, tk = 1;
        bit  seen = 1'b0;
        for (int n = 0; n < 400 && x_d !== 10'd100; n++) step();
        step();
        checks++;
        if (x_d !== 10'd100 || pt_d !== 1'b1) begin
            errors++; $display("FAIL pause_setup got x=%0d pt=%b want 100 1", x_d, pt_d);
        end
        en_d = 1'b0;
        #1;
        checks++;
        if (pt_d !== 1'b0) begin
            errors++; $display("FAIL pause_tick_gate got pt=%b want 0", pt_d);
        end
        repeat (37) begin
            step();
            if (x_d !== 10'd100 || y_d !== 10'd1 || pt_d !== 1'b0 || ls_d !== 1'b0 ||
                hs_d !== 1'b1 || vo_d !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL pause_hold got %0d bad cycles want 0", bad);
        end
        en_d = 1'b1;
        #1;
        checks++;
        if (pt_d !== 1'b1 || x_d !== 10'd100) begin
            errors++; $display("FAIL resume_tick got pt=%b x=%0d want 1 100", pt_d, x_d);
        end
        step();
        checks++;
        if (x_d !== 10'd101) begin
            errors++; $display("FAIL resume_next got x=%0d want 101", x_d);
        end
        for (int n = 0; n < 2000 && !seen; n++) begin
            if (ls_d === 1'b1) seen = 1'b1;
            else if (pt_d === 1'b1) tk++;
            if (!seen) step();
        end
        checks++;
        if (!seen || tk != 700 || y_d !== 10'd2) begin
            errors++; $display("FAIL pause_line_len got ticks=%0d y=%0d seen=%b want 700 2 1", tk, y_d, seen);
        end
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 2000 && x_d !== 10'd700; n++) step();
        checks++;
        if (x_d !== 10'd700 || hs_d !== 1'b0 || vo_d !== 1'b0) begin
            errors++; $display("FAIL arst_setup got x=%0d hs=%b vo=%b want 700 0 0", x_d, hs_d, vo_d);
        end
        #2;
        rst_d = 1'b0;
        #1;
        checks++;
        if (x_d !== 10'd0 || y_d !== 10'd0 || hs_d !== 1'b1 || vs_d !== 1'b1 ||
            vo_d !== 1'b1 || vb_d !== 1'b0 || pt_d !== 1'b0 || fc_d !== 8'd0) begin
            errors++; $display("FAIL arst_values got x=%0d y=%0d hs=%b vs=%b vo=%b vb=%b pt=%b fc=%0d want 0 0 1 1 1 0 0 0",
                               x_d, y_d, hs_d, vs_d, vo_d, vb_d, pt_d, fc_d);
        end
        #2;
        rst_d = 1'b1;
        step();
        checks++;
        if (pt_d !== 1'b1 || x_d !== 10'd0 || ls_d !== 1'b0) begin
            errors++; $display("FAIL arst_restart got pt=%b x=%0d ls=%b want 1 0 0", pt_d, x_d, ls_d);
        end
        step();
        checks++;
        if (x_d !== 10'd1 || y_d !== 10'd0) begin
            errors++; $display("FAIL arst_advance got x=%0d y=%0d want 1 0", x_d, y_d);
        end
    endtask

    task automatic test_frame();
        int  vs_min = 9999, vs_max = -1, vb_min = 9999, vb_max = -1;
        int  vb_bad = 0, ls_cnt = 0, ls_bad = 0, px = 0, py = 0, pfc = 0;
        bit  seen = 1'b0;
        rst_m = 1'b1;
        for (int n = 0; n < 12000 && !seen; n++) begin
            px = int'(x_m); py = int'(y_m); pfc = int'(fc_m);
            step();
            if (vs_m === 1'b0) begin
                if (int'(y_m) < vs_min) vs_min = int'(y_m);
                if (int'(y_m) > vs_max) vs_max = int'(y_m);
            end
            if (vb_m !== (y_m >= 10'd48)) vb_bad++;
            if (vb_m === 1'b1) begin
                if (int'(y_m) < vb_min) vb_min = int'(y_m);
                if (int'(y_m) > vb_max) vb_max = int'(y_m);
            end
            if (ls_m === 1'b1) begin
                ls_cnt++;
                if (x_m !== 10'd0) ls_bad++;
            end
            if (fs_m === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || px != 79 || py != 54 || pfc != 0) begin
            errors++; $display("FAIL frame_wrap_from got seen=%b (%0d,%0d) fc=%0d want 1 (79,54) 0", seen, px, py, pfc);
        end
        checks++;
        if (x_m !== 10'd0 || y_m !== 10'd0 || ls_m !== 1'b1 || fc_m !== 8'd1) begin
            errors++; $display("FAIL frame_wrap_to got (%0d,%0d) ls=%b fc=%0d want (0,0) 1 1", x_m, y_m, ls_m, fc_m);
        end
        checks++;
        if (vs_min != 50 || vs_max != 51) begin
            errors++; $display("FAIL vsync_window got %0d..%0d want 50..51", vs_min, vs_max);
        end
        checks++;
        if (vb_min != 48 || vb_max != 54 || vb_bad != 0) begin
            errors++; $display("FAIL vblank_window got %0d..%0d bad=%0d want 48..54 bad=0", vb_min, vb_max, vb_bad);
        end
        checks++;
        if (ls_cnt != 55 || ls_bad != 0) begin
            errors++; $display("FAIL line_count got %0d bad=%0d want 55 bad=0", ls_cnt, ls_bad);
        end
        step();
        checks++;
        if (fs_m !== 1'b0 || ls_m !== 1'b0 || fc_m !== 8'd1) begin
            errors++; $display("FAIL frame_strobe_width got fs=%b ls=%b fc=%0d want 0 0 1", fs_m, ls_m, fc_m);
        end
    endtask

    task automatic test_alt();
        int steps = 0, nfs = 0, nls = 0, fc_bad = 0, pt_bad = 0, hmin = 99, hmax = -1;
        checks++;
        if (pt_a !== 1'b0 || hs_a !== 1'b0 || vs_a !== 1'b0 || vo_a !== 1'b1) begin
            errors++; $display("FAIL alt_reset got pt=%b hs=%b vs=%b vo=%b want 0 0 0 1", pt_a, hs_a, vs_a, vo_a);
        end
        rst_a = 1'b1;
        #1;
        checks++;
        if (pt_a !== 1'b1) begin
            errors++; $display("FAIL alt_tick_release got pt=%b want 1", pt_a);
        end
        while (nfs < 256 && steps < 27500) begin
            step();
            steps++;
            if (pt_a !== 1'b1) pt_bad++;
            if (hs_a === 1'b1) begin
                if (int'(x_a) < hmin) hmin = int'(x_a);
                if (int'(x_a) > hmax) hmax = int'(x_a);
            end
            if (ls_a === 1'b1) nls++;
            if (fs_a === 1'b1) begin
                nfs++;
                if (fc_a !== 8'(nfs)) fc_bad++;
            end
        end
        checks++;
        if (nfs != 256 || steps != 26880) begin
            errors++; $display("FAIL alt_frame_len got frames=%0d clks=%0d want 256 26880", nfs, steps);
        end
        checks++;
        if (nls != 1792) begin
            errors++; $display("FAIL alt_line_count got %0d want 1792", nls);
        end
        checks++;
        if (pt_bad != 0) begin
            errors++; $display("FAIL alt_tick_const got %0d low cycles want 0", pt_bad);
        end
        checks++;
        if (hmin != 10 || hmax != 12) begin
            errors++; $display("FAIL alt_hsync_window got %0d..%0d want 10..12", hmin, hmax);
        end
        checks++;
        if (fc_bad != 0 || fc_a !== 8'd0) begin
            errors++; $display("FAIL alt_frame_wrap got bad=%0d fc=%0d want 0 0", fc_bad, fc_a);
        end
    endtask

    initial begin
        rst_d = 1'b0; en_d = 1'b1;
        rst_m = 1'b0; en_m = 1'b1;
        rst_a = 1'b0; en_a = 1'b1;
        test_reset();
        test_line();
        test_pause();
        test_async_reset();
        test_frame();
        test_alt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
